// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline sequencing controller: register-number width,
// controller state encoding and the packed latch-control bundle.
package cpu_types_pkg;

    localparam int REG_W = 5;

    typedef logic [REG_W-1:0] regbits_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        DRAIN   = 2'd2,
        HALTED  = 2'd3
    } pipe_state_t;

    // Bit order matches the field order below, MSB first.
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE     = 8'b00000_000;
    localparam ctrl_t CTRL_RUN      = 8'b11111_000;
    localparam ctrl_t CTRL_BRANCH   = 8'b11111_110;
    localparam ctrl_t CTRL_LOAD_USE = 8'b00111_010;
    localparam ctrl_t CTRL_FETCH_BB = 8'b01111_100;
    localparam ctrl_t CTRL_DRAIN    = 8'b01111_111;

endpackage

// File: rtl/pipeline_control_if.sv
// Latch-control bundle driven by pipeline_control: PC write enable plus the
// enable and flush lines of the four pipeline latches.
interface pipeline_control_if;

    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;

    modport ctrl (
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        output ifid_flush, idex_flush, exmem_flush
    );

    modport tb (
        input pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        input ifid_flush, idex_flush, exmem_flush
    );

endinterface

// File: rtl/pipeline_control_hazard_unit.sv
// Load-use detector: a load in EX whose destination feeds the instruction in ID.
// Register 0 is hardwired to zero, so a load targeting it never creates a hazard.
module hazard_unit
    import cpu_types_pkg::*;
(
    input  logic     memRead_ex,
    input  regbits_t rt_ex,
    input  regbits_t rs_id,
    input  regbits_t rt_id,
    output logic     load_use
);

    // Pure compare of the EX load destination against both ID sources.
    always_comb begin
        load_use = memRead_ex && (rt_ex != {REG_W{1'b0}}) &&
                   ((rt_ex == rs_id) || (rt_ex == rt_id));
    end

endmodule

// File: rtl/pipeline_control.sv
// Five-stage pipeline sequencing controller: stalls on data misses, resolves
// branch / load-use / fetch-miss priority and drains the pipe on halt.
// Optional performance counters are built only when PIPE_PERF_EN is defined.
module pipeline_control
    import cpu_types_pkg::*;
#(
    parameter int DRAIN_CYCLES = 1
`ifdef PIPE_PERF_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic     CLK,
    input  logic     nRST,
    input  logic     ihit,
    input  logic     dhit,
    input  logic     dREN_mem,
    input  logic     dWEN_mem,
    input  logic     halt_mem,
    input  logic     memRead_ex,
    input  regbits_t rt_ex,
    input  regbits_t rs_id,
    input  regbits_t rt_id,
    input  logic     branch_taken_ex,
    pipeline_control_if.ctrl ctl,
    output logic     halt_o
`ifdef PIPE_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
`endif
);

    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYCLES - 1);

    pipe_state_t    state_q, state_d;
    logic [DCW-1:0] drain_cnt_q, drain_cnt_d;
    logic           halt_o_q, halt_o_d;
    logic           load_use_s;
    logic           mem_pend_s;
    ctrl_t          run_ctl_s;
    ctrl_t          ctl_s;
    ctrl_t          ctl_out_s;

    hazard_unit u_hazard (
        .memRead_ex (memRead_ex),
        .rt_ex      (rt_ex),
        .rs_id      (rs_id),
        .rt_id      (rt_id),
        .load_use   (load_use_s)
    );

    // Outstanding data access that has not completed this cycle.
    always_comb begin
        mem_pend_s = (dREN_mem || dWEN_mem) && !dhit;
    end

    // RUN-state priority decision with the data-access condition already cleared.
    always_comb begin
        run_ctl_s = CTRL_RUN;
        if (halt_mem) begin
            run_ctl_s = CTRL_DRAIN;
        end else if (branch_taken_ex) begin
            run_ctl_s = CTRL_BRANCH;
        end else if (load_use_s) begin
            run_ctl_s = CTRL_LOAD_USE;
        end else if (!ihit) begin
            run_ctl_s = CTRL_FETCH_BB;
        end else begin
            run_ctl_s = CTRL_RUN;
        end
    end

    // Next-state, drain counter and raw latch controls.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        ctl_s       = CTRL_IDLE;
        case (state_q)
            RUN: begin
                if (mem_pend_s) begin
                    state_d = MEMWAIT;
                end else if (halt_mem) begin
                    ctl_s       = run_ctl_s;
                    state_d     = DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                end else begin
                    ctl_s   = run_ctl_s;
                    state_d = RUN;
                end
            end
            MEMWAIT: begin
                // Release cycle behaves exactly like RUN with the miss resolved.
                if (!dhit) begin
                    state_d = MEMWAIT;
                end else if (halt_mem) begin
                    ctl_s       = run_ctl_s;
                    state_d     = DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                end else begin
                    ctl_s   = run_ctl_s;
                    state_d = RUN;
                end
            end
            DRAIN: begin
                ctl_s = CTRL_DRAIN;
                if (drain_cnt_q == {DCW{1'b0}}) begin
                    state_d = HALTED;
                end else begin
                    drain_cnt_d = drain_cnt_q - DCW'(1);
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
            end
        endcase
        halt_o_d = (state_q == HALTED);
    end

    // Reset forces every enable and flush low without waiting for a clock.
    always_comb begin
        if (nRST) begin
            ctl_out_s = ctl_s;
        end else begin
            ctl_out_s = CTRL_IDLE;
        end
    end

    assign ctl.pc_en       = ctl_out_s.pc_en;
    assign ctl.ifid_en     = ctl_out_s.ifid_en;
    assign ctl.idex_en     = ctl_out_s.idex_en;
    assign ctl.exmem_en    = ctl_out_s.exmem_en;
    assign ctl.memwb_en    = ctl_out_s.memwb_en;
    assign ctl.ifid_flush  = ctl_out_s.ifid_flush;
    assign ctl.idex_flush  = ctl_out_s.idex_flush;
    assign ctl.exmem_flush = ctl_out_s.exmem_flush;
    assign halt_o          = halt_o_q;

    // Controller state, drain counter and registered halt flag.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= RUN;
            drain_cnt_q <= {DCW{1'b0}};
            halt_o_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            halt_o_q    <= halt_o_d;
        end
    end

`ifdef PIPE_PERF_EN
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;
    logic             stall_ev_s;
    logic             flush_ev_s;
    logic             run_eval_s;

    // Saturating event counters: a stall is any RUN/MEMWAIT cycle without a PC write,
    // a flush is a taken branch that actually wins arbitration.
    always_comb begin
        run_eval_s = ((state_q == RUN) && !mem_pend_s) || ((state_q == MEMWAIT) && dhit);
        stall_ev_s = ((state_q == RUN) || (state_q == MEMWAIT)) && !ctl_s.pc_en;
        flush_ev_s = run_eval_s && !halt_mem && branch_taken_ex;
        if (stall_ev_s && (stall_cycles_q != {CNT_W{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cycles_d = stall_cycles_q;
        end
        if (flush_ev_s && (flush_count_q != {CNT_W{1'b1}})) begin
            flush_count_d = flush_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            flush_count_d = flush_count_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cycles_q <= {CNT_W{1'b0}};
            flush_count_q  <= {CNT_W{1'b0}};
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule
